ks_adder_pipe: RTL and testbench



---
 rtl/ks_adder_pipe_pkg.sv | 23 ++
 rtl/ks_adder_pipe_prefix_cell.sv | 28 ++
 rtl/ks_adder_pipe.sv | 126 ++++++++++++
 tb/tb_ks_adder_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ks_adder_pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | ks_pkg                                                                     |
// | Shared types and helpers for the pipelined Kogge-Stone adder.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package ks_pkg;

  localparam int KS_MAX_WIDTH = 64;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ks_adder_pipe_prefix_cell.sv
// +----------------------------------------------------------------------------+
// | ks_prefix_cell                                                             |
// | Combinational Kogge-Stone black cell: merges (gi,pi) with (gj,pj).          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ks_prefix_cell
  import ks_pkg::*;
(
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic go,
  output logic po
);

  pg_t w_res;

  assign w_res.g = gi | (pi & gj);
  assign w_res.p = pi & pj;
  assign go      = w_res.g;
  assign po      = w_res.p;

endmodule

`default_nettype wire

// File: rtl/ks_adder_pipe.sv
// +----------------------------------------------------------------------------+
// | ks_adder_pipe                                                              |
// | Pipelined Kogge-Stone adder with valid/ready handshakes on both ends.      |
// | Optional KS_OVF_EN adds the signed-overflow output out_ovf.                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LEVELS  = ks_levels(WIDTH),
  parameter int LATENCY = LEVELS + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef KS_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  if (WIDTH < 2 || WIDTH > KS_MAX_WIDTH) begin : g_bad_width
    $error("ks_adder_pipe: WIDTH must be within 2..64");
  end
  if (LEVELS != ks_levels(WIDTH) || LATENCY != LEVELS + 1) begin : g_bad_levels
    $error("ks_adder_pipe: LEVELS/LATENCY are derived and must not be overridden");
  end

  // Stage k registers: valid, group G/P, raw P for the sum, and the carry-in.
  logic [LEVELS:0]            r_v;
  logic [LEVELS:0][WIDTH-1:0] r_g;
  logic [LEVELS:0][WIDTH-1:0] r_p;
  logic [LEVELS:0][WIDTH-1:0] r_rp;
  logic [LEVELS:0]            r_cin;

  logic [LEVELS:1][WIDTH-1:0] w_gn;
  logic [LEVELS:1][WIDTH-1:0] w_pn;
  logic [LEVELS:0]            w_rdy;
  logic [WIDTH-1:0]           w_g0;
  logic [WIDTH-1:0]           w_p0;
  logic                       w_unused_p;

  assign w_p0 = in_a ^ in_b;
  assign w_g0 = (in_a & in_b) | {{(WIDTH-1){1'b0}}, w_p0[0] & in_cin};

  // A stage may load if it or any stage below it is empty, or the sink takes data.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_ready
    assign w_rdy[k] = out_ready | ~(&r_v[LEVELS:k]);
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int DIST = 1 << (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= DIST) begin : g_cell
        ks_prefix_cell u_cell (
          .gi (r_g[k-1][i]),
          .pi (r_p[k-1][i]),
          .gj (r_g[k-1][i-DIST]),
          .pj (r_p[k-1][i-DIST]),
          .go (w_gn[k][i]),
          .po (w_pn[k][i])
        );
      end else begin : g_pass
        assign w_gn[k][i] = r_g[k-1][i];
        assign w_pn[k][i] = r_p[k-1][i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_g   <= '0;
      r_p   <= '0;
      r_rp  <= '0;
      r_cin <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_g[0]   <= w_g0;
          r_p[0]   <= w_p0;
          r_rp[0]  <= w_p0;
          r_cin[0] <= in_cin;
        end
      end
      for (int k = 1; k <= LEVELS; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= r_v[k-1];
          if (r_v[k-1]) begin
            r_g[k]   <= w_gn[k];
            r_p[k]   <= w_pn[k];
            r_rp[k]  <= r_rp[k-1];
            r_cin[k] <= r_cin[k-1];
          end
        end
      end
    end
  end

  // Final group propagate has no consumer once all carries are resolved.
  assign w_unused_p = ^r_p[LEVELS];

  assign in_ready  = w_rdy[0];
  assign out_valid = r_v[LEVELS];
  assign out_sum   = r_rp[LEVELS] ^ {r_g[LEVELS][WIDTH-2:0], r_cin[LEVELS]};
  assign out_cout  = r_g[LEVELS][WIDTH-1];

`ifdef KS_OVF_EN
  assign out_ovf   = r_g[LEVELS][WIDTH-2] ^ r_g[LEVELS][WIDTH-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe (WIDTH=16): directed vectors, stream,
// backpressure, bubble collapse and mid-stream reset.
`default_nettype none

module tb_ks_adder_pipe;

  localparam int W  = 16;
  localparam int LV = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef KS_OVF_EN
  logic         out_ovf;
`endif

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   gaps = 0;
  bit   stream_mode = 1'b0;
  bit   seen_first = 1'b0;

  ks_adder_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef KS_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic co, input logic ov);
    exp_t e;
    e.sum = s; e.cout = co; e.ovf = ov;
    return e;
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return mk(s[W-1:0], s[W], (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]));
  endfunction

  // Monitor: pops one expectation per accepted output.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got sum=%0h cout=%0b, expected no output", out_sum, out_cout);
      end else begin
        e = sb.pop_front();
        check("sum", 64'(out_sum), 64'(e.sum));
        check("cout", 64'(out_cout), 64'(e.cout));
`ifdef KS_OVF_EN
        check("ovf", 64'(out_ovf), 64'(e.ovf));
`endif
      end
      if (stream_mode) seen_first = 1'b1;
    end else if (rst_n && stream_mode && seen_first && !out_valid && sb.size() > 0) begin
      gaps++;
    end
  end

  // Issues one operand set; called and returns at posedge+1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input exp_t e, output int acc_cyc);
    int guard;
    guard = 0;
    acc_cyc = -1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    while (guard < 50) begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
    end
    if (guard >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: got in_ready=0, expected 1");
    end else begin
      acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Drives random operands for ncyc cycles, advancing only on acceptance.
  task automatic burst(input int ncyc, output int acc, output int first_block);
    logic [W-1:0] a, b;
    logic         c;
    bit           took;
    acc = 0; first_block = -1;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom_range(0, 1));
    for (int i = 0; i < ncyc; i++) begin
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
      @(negedge clk);
      took = in_ready;
      if (took) begin
        sb.push_back(model(a, b, c));
        acc++;
      end else if (first_block < 0) begin
        first_block = i;
      end
      @(posedge clk); #1;
      if (took) begin
        a = W'($urandom); b = W'($urandom); c = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() > 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int ac, oc, acc, fb, g, nvalid;
    logic [W-1:0] hold_sum;
    logic         hold_cout;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_cout", 64'(out_cout), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Single op latency
    send(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0), ac);
    g = 0; oc = -1;
    while (g < 50) begin
      @(negedge clk);
      if (out_valid) begin oc = cyc; break; end
      g++;
    end
    check("latency", 64'(oc - ac), 64'(LV + 1));
    drain();

    // Directed vectors, back to back
    send(16'hFFFF, 16'h0001, 1'b1, mk(16'h0001, 1'b1, 1'b0), ac);
    send(16'h1234, 16'h4321, 1'b1, mk(16'h5556, 1'b0, 1'b0), ac);
    send(16'h0000, 16'h0000, 1'b1, mk(16'h0001, 1'b0, 1'b0), ac);
    send(16'hFFFF, 16'hFFFF, 1'b1, mk(16'hFFFF, 1'b1, 1'b0), ac);
    send(16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1'b1, 1'b1), ac);
    send(16'hAAAA, 16'h5555, 1'b0, mk(16'hFFFF, 1'b0, 1'b0), ac);
    send(16'hAAAA, 16'h5555, 1'b1, mk(16'h0000, 1'b1, 1'b0), ac);
    send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1), ac);
    drain();

    // Stream at full rate
    stream_mode = 1'b1; seen_first = 1'b0; gaps = 0;
    burst(300, acc, fb);
    check("stream_accepted", 64'(acc), 64'd300);
    check("stream_in_ready_drop", 64'(fb), 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    stream_mode = 1'b0;
    check("stream_gaps", 64'(gaps), 64'd0);

    // Backpressure
    out_ready = 1'b0;
    burst(10, acc, fb);
    check("bp_accepted", 64'(acc), 64'(LV + 1));
    check("bp_first_block", 64'(fb), 64'(LV + 1));
    @(negedge clk);
    hold_sum = out_sum; hold_cout = out_cout;
    repeat (3) @(negedge clk);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_hold_sum", 64'(out_sum), 64'(hold_sum));
    check("bp_hold_cout", 64'(out_cout), 64'(hold_cout));
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Bubble collapse
    send(16'h0F0F, 16'h00F1, 1'b0, mk(16'h1000, 1'b0, 1'b0), ac);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    burst(10, acc, fb);
    check("bubble_accepted", 64'(acc), 64'(LV));
    check("bubble_first_block", 64'(fb), 64'(LV));
    out_ready = 1'b1;
    drain();

    // Reset with transactions in flight
    send(16'h0001, 16'h0002, 1'b0, mk(16'h0003, 1'b0, 1'b0), ac);
    send(16'h0010, 16'h0020, 1'b0, mk(16'h0030, 1'b0, 1'b0), ac);
    send(16'h0100, 16'h0200, 1'b0, mk(16'h0300, 1'b0, 1'b0), ac);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nvalid = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    check("post_reset_valid", 64'(nvalid), 64'd0);
    @(posedge clk); #1;
    send(16'h1234, 16'h4321, 1'b1, mk(16'h5556, 1'b0, 1'b0), ac);
    send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1), ac);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
